// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with LRU replacement, flush and hit/miss counters
module icache_assoc #(
    parameter int ADDR_W = 10,
    parameter int WPB    = 4,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 address,
    input  logic                              read,
    input  logic                              flush,
    output logic [31:0]                       readinst,
    output logic                              busywait,
    output logic                              mem_read,
    output logic [ADDR_W-3-$clog2(WPB):0]     mem_address,
    input  logic [32*WPB-1:0]                 mem_inst,
    input  logic                              mem_busywait,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [CNT_W-1:0]                  miss_count
);

    localparam int OFF_W  = $clog2(WPB);
    localparam int IDX_W  = $clog2(SETS);
    localparam int BLK_W  = ADDR_W - 2 - OFF_W;
    localparam int TAG_W  = BLK_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, MEM_READ, FILL} state_t;

    state_t state;

    logic [31:0]       data_arr [SETS][WAYS][WPB];
    logic [TAG_W-1:0]  tag_arr  [SETS][WAYS];
    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  age      [SETS][WAYS];

    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic [IDX_WS-1:0] req_idx, fill_idx, touch_idx;
    logic [OFF_WS-1:0] req_off;
    logic [WAY_W-1:0]  hit_way, victim, victim_r, touch_way, touch_ref, best_age;
    logic              hit, found_free, accept, hit_acc, miss_acc, fill_now, touch_en;
    logic              unused_addr_bits;

    assign unused_addr_bits = &{1'b0, address[1:0]};
    assign req_tag  = address[ADDR_W-1 -: TAG_W];
    assign fill_tag = mem_address[BLK_W-1 -: TAG_W];

    generate
        if (IDX_W > 0) begin : g_idx
            assign req_idx  = address[OFF_W+2 +: IDX_W];
            assign fill_idx = mem_address[0 +: IDX_W];
        end else begin : g_no_idx
            assign req_idx  = '0;
            assign fill_idx = '0;
        end
        if (OFF_W > 0) begin : g_off
            assign req_off = address[2 +: OFF_W];
        end else begin : g_no_off
            assign req_off = '0;
        end
    endgenerate

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way first, otherwise the lowest-numbered oldest way.
    always_comb begin
        victim     = '0;
        found_free = 1'b0;
        best_age   = age[req_idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!found_free && !valid[req_idx][w]) begin
                found_free = 1'b1;
                victim     = WAY_W'(w);
            end
        end
        if (!found_free) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age[req_idx][w] > best_age) begin
                    best_age = age[req_idx][w];
                    victim   = WAY_W'(w);
                end
            end
        end
    end

    assign accept   = (state == IDLE) && read && !flush;
    assign hit_acc  = accept && hit;
    assign miss_acc = accept && !hit;
    assign fill_now = (state == MEM_READ) && !mem_busywait;

    assign busywait = (state != IDLE) || (read && (flush || !hit));
    assign readinst = hit_acc ? data_arr[req_idx][hit_way][req_off] : 32'h0;

    // A freshly filled invalid way is treated as the oldest, so ages settle into a permutation.
    assign touch_en  = hit_acc || fill_now;
    assign touch_idx = fill_now ? fill_idx : req_idx;
    assign touch_way = fill_now ? victim_r : hit_way;
    assign touch_ref = valid[touch_idx][touch_way] ? age[touch_idx][touch_way] : AGE_MAX;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            victim_r    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else begin
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age[touch_idx][w] <= '0;
                    else if (age[touch_idx][w] < touch_ref)
                        age[touch_idx][w] <= age[touch_idx][w] + WAY_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
                        end
                    end else if (hit_acc) begin
                        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                    end else if (miss_acc) begin
                        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        victim_r    <= victim;
                        mem_read    <= 1'b1;
                        mem_address <= address[ADDR_W-1 -: BLK_W];
                        state       <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        valid[fill_idx][victim_r] <= 1'b1;
                        mem_read    <= 1'b0;
                        mem_address <= '0;
                        state       <= FILL;
                    end
                end
                FILL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && fill_now) begin
            tag_arr[fill_idx][victim_r] <= fill_tag;
            for (int k = 0; k < WPB; k++)
                data_arr[fill_idx][victim_r][k] <= mem_inst[32*k +: 32];
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed self-checking bench for icache_assoc
module tb_icache_assoc;

    logic         clock, reset, read, flush, mem_busywait;
    logic [9:0]   address;
    logic [31:0]  readinst;
    logic         busywait, mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_inst;
    logic [15:0]  hit_count, miss_count;

    int vectors = 0;
    int miscompares = 0;
    int n, mr;
    logic [5:0] ma;

    icache_assoc dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .flush(flush),
        .readinst(readinst), .busywait(busywait), .mem_read(mem_read),
        .mem_address(mem_address), .mem_inst(mem_inst), .mem_busywait(mem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word(input int blk, input int k);
        return 32'hA500_0000 | (32'(blk) << 8) | 32'(k);
    endfunction

    always_comb begin
        mem_inst = '0;
        for (int k = 0; k < 4; k++) mem_inst[32*k +: 32] = word(int'(mem_address), k);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory responds (mem_busywait low) on the lat-th cycle of mem_read.
    task automatic do_miss(input logic [9:0] a, input int lat,
                           output int cyc, output logic [5:0] addr_seen, output int mr_cyc);
        address = a;
        read = 1'b1;
        mem_busywait = 1'b1;
        cyc = 0;
        mr_cyc = 0;
        addr_seen = 6'h3F;
        #1;
        while (busywait === 1'b1 && cyc < 50) begin
            cyc++;
            if (mem_read === 1'b1) begin
                mr_cyc++;
                addr_seen = mem_address;
            end
            mem_busywait = (mem_read === 1'b1 && mr_cyc >= lat) ? 1'b0 : 1'b1;
            tick();
        end
        mem_busywait = 1'b1;
    endtask

    task automatic do_hit(input logic [9:0] a, input logic [31:0] exp, input string tag);
        address = a;
        read = 1'b1;
        #1;
        check({tag, ".busy"}, busywait, 32'h0);
        check({tag, ".data"}, readinst, exp);
        check({tag, ".mem_read"}, mem_read, 32'h0);
        tick();
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; flush = 1'b0; mem_busywait = 1'b1; address = '0;
        repeat (2) tick();
        check("rst.busy", busywait, 0);
        check("rst.mem_read", mem_read, 0);
        check("rst.mem_addr", mem_address, 0);
        check("rst.readinst", readinst, 0);
        check("rst.hits", hit_count, 0);
        check("rst.misses", miss_count, 0);
        reset = 1'b0;
        tick();

        do_miss(10'h000, 5, n, ma, mr);
        check("m0.busy_cycles", n, 7);
        check("m0.mem_cycles", mr, 5);
        check("m0.mem_addr", ma, 6'h00);
        check("m0.readinst", readinst, word(0, 0));
        tick();
        read = 1'b0;
        check("m0.misses", miss_count, 1);
        check("m0.hits", hit_count, 1);

        do_hit(10'h004, word(0, 1), "h1");
        do_hit(10'h008, word(0, 2), "h2");
        do_hit(10'h00C, word(0, 3), "h3");
        check("h.hits", hit_count, 4);

        do_miss(10'h040, 1, n, ma, mr);
        check("c40.busy_cycles", n, 3);
        check("c40.mem_addr", ma, 6'h04);
        check("c40.readinst", readinst, word(4, 0));
        tick();
        read = 1'b0;
        do_hit(10'h000, word(0, 0), "touch0");
        do_miss(10'h080, 2, n, ma, mr);
        check("c80.busy_cycles", n, 4);
        check("c80.mem_addr", ma, 6'h08);
        check("c80.readinst", readinst, word(8, 0));
        tick();
        read = 1'b0;
        do_hit(10'h000, word(0, 0), "keep0");
        do_miss(10'h040, 1, n, ma, mr);
        check("re40.busy_cycles", n, 3);
        check("re40.mem_addr", ma, 6'h04);
        tick();
        read = 1'b0;
        check("c.hits", hit_count, 9);
        check("c.misses", miss_count, 4);

        address = 10'h000; read = 1'b1; flush = 1'b1;
        #1;
        check("fr.busy", busywait, 1);
        check("fr.readinst", readinst, 0);
        tick();
        flush = 1'b0;
        do_miss(10'h000, 1, n, ma, mr);
        check("fr.busy_cycles", n, 3);
        check("fr.mem_cycles", mr, 1);
        check("fr.readinst", readinst, word(0, 0));
        tick();
        read = 1'b0;
        check("fr.misses", miss_count, 5);
        check("fr.hits", hit_count, 10);

        flush = 1'b1;
        #1;
        check("f.busy", busywait, 0);
        tick();
        flush = 1'b0;
        do_miss(10'h004, 1, n, ma, mr);
        check("f.busy_cycles", n, 3);
        check("f.readinst", readinst, word(0, 1));
        tick();
        read = 1'b0;

        address = 10'h100; read = 1'b1; mem_busywait = 1'b1;
        tick();
        tick();
        check("rm.mem_read", mem_read, 1);
        check("rm.mem_addr", mem_address, 6'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0; read = 1'b0;
        #1;
        check("rm.mem_read_after", mem_read, 0);
        check("rm.mem_addr_after", mem_address, 0);
        check("rm.busy_after", busywait, 0);
        check("rm.hits", hit_count, 0);
        check("rm.misses", miss_count, 0);
        mem_busywait = 1'b0;
        tick();
        mem_busywait = 1'b1;
        check("rm.late_ignored", mem_read, 0);
        read = 1'b1;
        #1;
        check("rm.not_valid", busywait, 1);
        do_miss(10'h100, 1, n, ma, mr);
        check("rm.busy_cycles", n, 3);
        check("rm.refill_addr", ma, 6'h10);
        check("rm.readinst", readinst, word(16, 0));
        tick();
        read = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_miss(10'h000, 1, n, ma, mr);
        repeat (65534) tick();
        check("sat.fffe", hit_count, 16'hFFFE);
        tick();
        check("sat.ffff", hit_count, 16'hFFFF);
        repeat (2) tick();
        check("sat.hold", hit_count, 16'hFFFF);
        check("sat.misses", miss_count, 1);
        read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
